// File: rtl/ex_pkg.sv
// Shared constants and types for the execute stage: ALU op codes, R-type funct
// codes, multiplier FSM states and the control bundle carried down the pipe.
package ex_pkg;
  localparam int DW_DEFAULT     = 32;
  localparam int MUL_CYCLES_DEF = 32;

  localparam logic [1:0] OP_ADD   = 2'b00;
  localparam logic [1:0] OP_SUB   = 2'b01;
  localparam logic [1:0] OP_RTYPE = 2'b10;
  localparam logic [1:0] OP_OR    = 2'b11;

  localparam logic [5:0] F_ADD = 6'h20;
  localparam logic [5:0] F_SUB = 6'h22;
  localparam logic [5:0] F_AND = 6'h24;
  localparam logic [5:0] F_OR  = 6'h25;
  localparam logic [5:0] F_SLT = 6'h2A;
  localparam logic [5:0] F_MUL = 6'h18;

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_e;

  typedef struct packed {
    logic       regwrite;
    logic       mem2reg;
    logic       memread;
    logic       memwrite;
    logic [4:0] waddr;
  } ctrl_t;
endpackage

// File: rtl/ex_stage_if.sv
// ID/EX -> EX -> EX/MEM bundle plus the MEM/WB forwarding tap.
// slave = execute stage side, master = surrounding pipeline / bench.
interface ex_stage_if #(parameter int DW = ex_pkg::DW_DEFAULT);
  logic          in_valid, flush;
  logic          RegWrite_in, Mem2Reg_in, MemRead_in, MemWrite_in;
  logic [1:0]    ALUOp_in;
  logic          RegDst_in, ALU_Src_in;
  logic [4:0]    RsAddr_in, RtAddr_in, RdAddr_in;
  logic [DW-1:0] RsData_in, RtData_in, immediate_in;
  logic          wb_RegWrite;
  logic [4:0]    wb_WriteAddr;
  logic [DW-1:0] wb_data;
  logic          stall_o, ex_valid;
  logic          RegWrite_out, Mem2Reg_out, MemRead_out, MemWrite_out;
  logic [DW-1:0] alu_result, store_data;
  logic [4:0]    WriteAddr_out;

  modport slave (
    input  in_valid, flush, RegWrite_in, Mem2Reg_in, MemRead_in, MemWrite_in,
           ALUOp_in, RegDst_in, ALU_Src_in, RsAddr_in, RtAddr_in, RdAddr_in,
           RsData_in, RtData_in, immediate_in, wb_RegWrite, wb_WriteAddr, wb_data,
    output stall_o, ex_valid, RegWrite_out, Mem2Reg_out, MemRead_out, MemWrite_out,
           alu_result, store_data, WriteAddr_out
  );

  modport master (
    output in_valid, flush, RegWrite_in, Mem2Reg_in, MemRead_in, MemWrite_in,
           ALUOp_in, RegDst_in, ALU_Src_in, RsAddr_in, RtAddr_in, RdAddr_in,
           RsData_in, RtData_in, immediate_in, wb_RegWrite, wb_WriteAddr, wb_data,
    input  stall_o, ex_valid, RegWrite_out, Mem2Reg_out, MemRead_out, MemWrite_out,
           alu_result, store_data, WriteAddr_out
  );
endinterface

// File: rtl/mul_iter32.sv
// Iterative shift-add multiplier: start loads operands, each step consumes one
// multiplier bit. last_o flags the step that completes the product.
module mul_iter32 #(
  parameter int DW         = 32,
  parameter int MUL_CYCLES = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start_i,
  input  logic          step_i,
  input  logic          clr_i,
  input  logic [DW-1:0] a_i,
  input  logic [DW-1:0] b_i,
  output logic          last_o,
  output logic [DW-1:0] prod_o
);
  localparam int CW = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;

  logic [DW-1:0] mcand_q, mcand_d, mplier_q, mplier_d, acc_q, acc_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    if (clr_i) begin
      mcand_d  = '0;
      mplier_d = '0;
      acc_d    = '0;
      cnt_d    = '0;
    end else if (start_i) begin
      mcand_d  = a_i;
      mplier_d = b_i;
      acc_d    = '0;
      cnt_d    = '0;
    end else if (step_i) begin
      if (mplier_q[0]) acc_d = acc_q + mcand_q;
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
    end else begin
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
    end
  end

  assign last_o = (cnt_q == CW'(MUL_CYCLES - 1));
  assign prod_o = acc_q;
endmodule

// File: rtl/ex_stage.sv
// Execute stage: operand forwarding, single-cycle ALU, iterative MUL with
// ID/EX stall, and the EX/MEM pipeline register. MUL_CYCLES must equal DW.
module ex_stage #(
  parameter int MUL_CYCLES = ex_pkg::MUL_CYCLES_DEF,
  parameter int DW         = ex_pkg::DW_DEFAULT
) (
  input logic       clk,
  input logic       rst_n,
  ex_stage_if.slave bus
);
  import ex_pkg::*;

  state_e        state_q, state_d;
  ctrl_t         ctrl_in, out_ctrl_q, out_ctrl_d, cap_ctrl_q, cap_ctrl_d;
  logic          ex_valid_q, ex_valid_d;
  logic [DW-1:0] alu_q, alu_d, st_q, st_d, cap_st_q, cap_st_d;
  logic [DW-1:0] op_a, rt_fwd, op_b, alu_res, prod;
  logic [5:0]    funct;
  logic          is_mul, exm_src_ok, mul_start, mul_step, mul_last;

  assign funct   = bus.immediate_in[5:0];
  assign is_mul  = (bus.ALUOp_in == OP_RTYPE) && (funct == F_MUL);
  assign ctrl_in = '{regwrite: bus.RegWrite_in, mem2reg: bus.Mem2Reg_in,
                     memread:  bus.MemRead_in,  memwrite: bus.MemWrite_in,
                     waddr:    bus.RegDst_in ? bus.RdAddr_in : bus.RtAddr_in};

  // A load result in EX/MEM is not yet known, so only ALU results forward from there.
  assign exm_src_ok = ex_valid_q & out_ctrl_q.regwrite & ~out_ctrl_q.mem2reg;

  assign op_a =
    (exm_src_ok && out_ctrl_q.waddr == bus.RsAddr_in && bus.RsAddr_in != 5'd0) ? alu_q :
    (bus.wb_RegWrite && bus.wb_WriteAddr == bus.RsAddr_in && bus.RsAddr_in != 5'd0) ? bus.wb_data :
    bus.RsData_in;
  assign rt_fwd =
    (exm_src_ok && out_ctrl_q.waddr == bus.RtAddr_in && bus.RtAddr_in != 5'd0) ? alu_q :
    (bus.wb_RegWrite && bus.wb_WriteAddr == bus.RtAddr_in && bus.RtAddr_in != 5'd0) ? bus.wb_data :
    bus.RtData_in;
  assign op_b = bus.ALU_Src_in ? bus.immediate_in : rt_fwd;

  always_comb begin
    alu_res = '0;
    case (bus.ALUOp_in)
      OP_ADD:  alu_res = op_a + op_b;
      OP_SUB:  alu_res = op_a - op_b;
      OP_OR:   alu_res = op_a | op_b;
      default: begin
        case (funct)
          F_ADD:   alu_res = op_a + op_b;
          F_SUB:   alu_res = op_a - op_b;
          F_AND:   alu_res = op_a & op_b;
          F_OR:    alu_res = op_a | op_b;
          F_SLT:   alu_res = {{(DW-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
          default: alu_res = '0;
        endcase
      end
    endcase
  end

  mul_iter32 #(.DW(DW), .MUL_CYCLES(MUL_CYCLES)) u_mul (
    .clk    (clk),
    .rst_n  (rst_n),
    .start_i(mul_start),
    .step_i (mul_step),
    .clr_i  (bus.flush),
    .a_i    (op_a),
    .b_i    (op_b),
    .last_o (mul_last),
    .prod_o (prod)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (bus.flush) state_d = S_IDLE;
    else begin
      case (state_q)
        S_IDLE:  if (bus.in_valid && is_mul) state_d = S_BUSY;
        S_BUSY:  if (mul_last) state_d = S_DONE;
        S_DONE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Default everything to a bubble; only a real result overrides it.
  always_comb begin
    ex_valid_d = 1'b0;
    out_ctrl_d = '0;
    alu_d      = '0;
    st_d       = '0;
    cap_ctrl_d = cap_ctrl_q;
    cap_st_d   = cap_st_q;
    mul_start  = 1'b0;
    mul_step   = 1'b0;
    if (!bus.flush) begin
      case (state_q)
        S_IDLE: begin
          if (bus.in_valid && is_mul) begin
            mul_start  = 1'b1;
            cap_ctrl_d = ctrl_in;
            cap_st_d   = rt_fwd;
          end else if (bus.in_valid) begin
            ex_valid_d = 1'b1;
            out_ctrl_d = ctrl_in;
            alu_d      = alu_res;
            st_d       = rt_fwd;
          end
        end
        S_BUSY: mul_step = 1'b1;
        S_DONE: begin
          ex_valid_d = 1'b1;
          out_ctrl_d = cap_ctrl_q;
          alu_d      = prod;
          st_d       = cap_st_q;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid_q <= 1'b0;
      out_ctrl_q <= '0;
      alu_q      <= '0;
      st_q       <= '0;
      cap_ctrl_q <= '0;
      cap_st_q   <= '0;
    end else begin
      ex_valid_q <= ex_valid_d;
      out_ctrl_q <= out_ctrl_d;
      alu_q      <= alu_d;
      st_q       <= st_d;
      cap_ctrl_q <= cap_ctrl_d;
      cap_st_q   <= cap_st_d;
    end
  end

  assign bus.stall_o       = rst_n & bus.in_valid & is_mul & (state_q != S_DONE) & ~bus.flush;
  assign bus.ex_valid      = ex_valid_q;
  assign bus.RegWrite_out  = out_ctrl_q.regwrite;
  assign bus.Mem2Reg_out   = out_ctrl_q.mem2reg;
  assign bus.MemRead_out   = out_ctrl_q.memread;
  assign bus.MemWrite_out  = out_ctrl_q.memwrite;
  assign bus.WriteAddr_out = out_ctrl_q.waddr;
  assign bus.alu_result    = alu_q;
  assign bus.store_data    = st_q;
endmodule

// File: tb/tb_ex_stage.sv
// Directed plus randomized checks of ex_stage against a behavioural model of the
// EX/MEM register (forwarding rules, ALU arithmetic, MUL latency, flush, reset).
module tb_ex_stage;
  import ex_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ex_stage_if #(.DW(32)) bus ();
  ex_stage #(.MUL_CYCLES(32), .DW(32)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  typedef struct packed {
    logic v; logic [1:0] op; logic src, dst, rw, m2r, mr, mw;
    logic [4:0] rs, rt, rd; logic [31:0] rsd, rtd, imm;
  } instr_t;

  int checks = 0;
  int errors = 0;

  // Model of what EX/MEM should currently hold.
  logic        m_valid;
  ctrl_t       m_ctl;
  logic [31:0] m_res;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  function automatic instr_t r_ins(logic [5:0] f, logic [4:0] rs, logic [4:0] rt,
                                   logic [4:0] rd, logic [31:0] rsd, logic [31:0] rtd);
    instr_t i = '0;
    i.v = 1'b1; i.op = OP_RTYPE; i.dst = 1'b1; i.rw = 1'b1;
    i.rs = rs; i.rt = rt; i.rd = rd; i.rsd = rsd; i.rtd = rtd; i.imm = {26'd0, f};
    return i;
  endfunction

  task automatic drive(instr_t i);
    bus.in_valid = i.v; bus.ALUOp_in = i.op; bus.ALU_Src_in = i.src; bus.RegDst_in = i.dst;
    bus.RegWrite_in = i.rw; bus.Mem2Reg_in = i.m2r; bus.MemRead_in = i.mr; bus.MemWrite_in = i.mw;
    bus.RsAddr_in = i.rs; bus.RtAddr_in = i.rt; bus.RdAddr_in = i.rd;
    bus.RsData_in = i.rsd; bus.RtData_in = i.rtd; bus.immediate_in = i.imm;
  endtask

  task automatic set_wb(logic rw, logic [4:0] a, logic [31:0] d);
    bus.wb_RegWrite = rw; bus.wb_WriteAddr = a; bus.wb_data = d;
  endtask

  // Register value the instruction should see for address a.
  function automatic logic [31:0] fwd_m(logic [4:0] a, logic [31:0] d);
    if (a == 5'd0) return d;
    if (m_valid && m_ctl.regwrite && !m_ctl.mem2reg && m_ctl.waddr == a) return m_res;
    if (bus.wb_RegWrite && bus.wb_WriteAddr == a) return bus.wb_data;
    return d;
  endfunction

  function automatic logic [31:0] alu_m(logic [31:0] a, logic [31:0] b, logic [1:0] op, logic [5:0] f);
    logic [31:0] r;
    r = 32'd0;
    if (op == 2'b00) r = a + b;
    else if (op == 2'b01) r = a - b;
    else if (op == 2'b11) r = a | b;
    else if (f == 6'h20) r = a + b;
    else if (f == 6'h22) r = a - b;
    else if (f == 6'h24) r = a & b;
    else if (f == 6'h25) r = a | b;
    else if (f == 6'h2A) r = (int'(a) < int'(b)) ? 32'd1 : 32'd0;
    else if (f == 6'h18) r = a * b;
    return r;
  endfunction

  function automatic ctrl_t ctl_of_inputs();
    ctrl_t c;
    c.regwrite = bus.RegWrite_in; c.mem2reg = bus.Mem2Reg_in;
    c.memread = bus.MemRead_in; c.memwrite = bus.MemWrite_in;
    c.waddr = bus.RegDst_in ? bus.RdAddr_in : bus.RtAddr_in;
    return c;
  endfunction

  function automatic logic [31:0] obs_ctl();
    return 32'({bus.RegWrite_out, bus.Mem2Reg_out, bus.MemRead_out, bus.MemWrite_out, bus.WriteAddr_out});
  endfunction

  task automatic check_outputs(string tag, logic ev, ctrl_t ec, logic [31:0] eres, logic [31:0] est);
    chk({tag, ".valid"}, 32'(bus.ex_valid), 32'(ev));
    chk({tag, ".ctl"}, obs_ctl(), 32'(ec));
    if (ev) begin
      chk({tag, ".res"}, bus.alu_result, eres);
      chk({tag, ".st"}, bus.store_data, est);
    end
    m_valid = ev; m_ctl = ec; m_res = eres;
  endtask

  // One non-MUL instruction (or bubble) through one edge.
  task automatic run1(string tag);
    logic ev; logic [31:0] a, rt, b, res; ctrl_t ec;
    ev = bus.in_valid & ~bus.flush;
    a  = fwd_m(bus.RsAddr_in, bus.RsData_in);
    rt = fwd_m(bus.RtAddr_in, bus.RtData_in);
    b  = bus.ALU_Src_in ? bus.immediate_in : rt;
    res = alu_m(a, b, bus.ALUOp_in, bus.immediate_in[5:0]);
    ec = ev ? ctl_of_inputs() : '0;
    @(posedge clk); #1;
    check_outputs(tag, ev, ec, res, rt);
  endtask

  // MUL already driven; optionally disturb operand sources once captured.
  task automatic run_mul(string tag, bit scramble);
    logic [31:0] a, rt, b, prod; ctrl_t ec; int n, bad;
    a  = fwd_m(bus.RsAddr_in, bus.RsData_in);
    rt = fwd_m(bus.RtAddr_in, bus.RtData_in);
    b  = bus.ALU_Src_in ? bus.immediate_in : rt;
    prod = a * b;
    ec = ctl_of_inputs();
    n = 0; bad = 0;
    #1;
    while (bus.stall_o === 1'b1 && n < 100) begin
      @(posedge clk); #1;
      n++;
      if (bus.ex_valid !== 1'b0) bad++;
      if (scramble) begin
        bus.RsData_in = $urandom; bus.RtData_in = $urandom;
        set_wb(1'b1, bus.RsAddr_in, $urandom);
      end
    end
    chk({tag, ".stall_cycles"}, 32'(n), 32'd33);
    chk({tag, ".bubbles"}, 32'(bad), 32'd0);
    @(posedge clk); #1;
    check_outputs(tag, 1'b1, ec, prod, rt);
  endtask

  task automatic chk_reset(string tag);
    chk({tag, ".valid"}, 32'(bus.ex_valid), 32'd0);
    chk({tag, ".ctl"}, obs_ctl(), 32'd0);
    chk({tag, ".res"}, bus.alu_result, 32'd0);
    chk({tag, ".st"}, bus.store_data, 32'd0);
    chk({tag, ".stall"}, 32'(bus.stall_o), 32'd0);
    m_valid = 1'b0; m_ctl = '0; m_res = '0;
  endtask

  initial begin
    instr_t i;
    logic [5:0] fl [6] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h3F};
    bus.flush = 1'b0;
    drive('0);
    set_wb(1'b0, 5'd0, 32'd0);
    m_valid = 1'b0; m_ctl = '0; m_res = '0;

    #12;
    chk_reset("reset");
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    // Forwarding
    drive(r_ins(F_ADD, 5'd7, 5'd8, 5'd1, 32'd5, 32'd6));   run1("add_r1");
    chk("add_r1.const", bus.alu_result, 32'd11);
    drive(r_ins(F_ADD, 5'd1, 5'd1, 5'd2, 32'd0, 32'd0));   run1("fwd_exm");
    chk("fwd_exm.const", bus.alu_result, 32'd22);
    set_wb(1'b1, 5'd1, 32'd9);
    drive(r_ins(F_ADD, 5'd1, 5'd1, 5'd3, 32'd0, 32'd0));   run1("fwd_wb");
    chk("fwd_wb.const", bus.alu_result, 32'd18);
    drive(r_ins(F_ADD, 5'd7, 5'd8, 5'd0, 32'd100, 32'd1)); run1("wr_r0");
    set_wb(1'b1, 5'd0, 32'd77);
    drive(r_ins(F_ADD, 5'd0, 5'd0, 5'd4, 32'd5, 32'd6));   run1("no_fwd_r0");
    chk("no_fwd_r0.const", bus.alu_result, 32'd11);
    set_wb(1'b0, 5'd0, 32'd0);

    // MUL latency, operand immunity, back-to-back with forwarded operands
    drive(r_ins(F_MUL, 5'd10, 5'd11, 5'd12, 32'hFFFF_FFFF, 32'd3)); run_mul("mul", 1'b1);
    chk("mul.const", bus.alu_result, 32'hFFFF_FFFD);
    drive(r_ins(F_MUL, 5'd12, 5'd12, 5'd13, 32'd0, 32'd0)); run_mul("mul_b2b", 1'b0);
    set_wb(1'b0, 5'd0, 32'd0);

    // slt and unknown funct
    drive(r_ins(F_SLT, 5'd7, 5'd8, 5'd9, 32'hFFFF_FFFF, 32'd1)); run1("slt_neg");
    chk("slt_neg.const", bus.alu_result, 32'd1);
    drive(r_ins(F_SLT, 5'd7, 5'd8, 5'd9, 32'd1, 32'hFFFF_FFFF)); run1("slt_pos");
    chk("slt_pos.const", bus.alu_result, 32'd0);
    i = r_ins(6'h3F, 5'd7, 5'd8, 5'd9, 32'd3, 32'd4); i.mr = 1'b1; i.mw = 1'b1; i.m2r = 1'b1;
    drive(i); run1("unk_funct");

    // Bubble, then store with immediate and forwarded Rt
    i = r_ins(F_ADD, 5'd7, 5'd8, 5'd9, 32'd3, 32'd4); i.v = 1'b0; i.mw = 1'b1;
    drive(i); run1("bubble");
    set_wb(1'b1, 5'd5, 32'hAB);
    i = '0; i.v = 1'b1; i.op = OP_ADD; i.src = 1'b1; i.imm = 32'd8; i.rs = 5'd6; i.rsd = 32'h100;
    i.rt = 5'd5; i.mw = 1'b1;
    drive(i); run1("sw");
    chk("sw.addr", bus.alu_result, 32'h108);
    chk("sw.data", bus.store_data, 32'hAB);
    set_wb(1'b0, 5'd0, 32'd0);
    rst_n = 1'b0; #1;
    chk_reset("reset_clear");
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    // Flush in BUSY cycle 10
    drive(r_ins(F_MUL, 5'd7, 5'd8, 5'd9, 32'd5, 32'd6));
    repeat (11) @(posedge clk);
    #1;
    bus.flush = 1'b1; #1;
    chk("flush.stall", 32'(bus.stall_o), 32'd0);
    @(posedge clk); #1;
    chk("flush.valid", 32'(bus.ex_valid), 32'd0);
    m_valid = 1'b0; m_ctl = '0;
    bus.flush = 1'b0;
    drive(r_ins(F_ADD, 5'd7, 5'd8, 5'd9, 32'd1, 32'd1)); run1("after_flush");
    chk("after_flush.const", bus.alu_result, 32'd2);
    i = '0; drive(i); run1("after_flush_idle");

    // Reset mid-MUL aborts it
    drive(r_ins(F_MUL, 5'd7, 5'd8, 5'd9, 32'd5, 32'd6));
    repeat (5) @(posedge clk);
    #1;
    rst_n = 1'b0; #1;
    chk_reset("reset_mid");
    drive(r_ins(F_ADD, 5'd7, 5'd8, 5'd9, 32'd3, 32'd4));
    @(negedge clk) rst_n = 1'b1;
    run1("post_reset_add");
    chk("post_reset_add.const", bus.alu_result, 32'd7);

    // Randomized mix
    for (int n = 0; n < 60; n++) begin
      int k;
      i = '0;
      i.v = ($urandom_range(0, 9) != 0);
      k = $urandom_range(0, 7);
      i.op = (k == 0) ? OP_ADD : (k == 1) ? OP_SUB : (k == 2) ? OP_OR : OP_RTYPE;
      i.src = (i.op != OP_RTYPE) && ($urandom_range(0, 1) == 1);
      i.dst = 1'($urandom_range(0, 1)); i.rw = 1'($urandom_range(0, 1));
      i.m2r = ($urandom_range(0, 3) == 0); i.mr = 1'($urandom_range(0, 1)); i.mw = 1'($urandom_range(0, 1));
      i.rs = 5'($urandom_range(0, 3)); i.rt = 5'($urandom_range(0, 3)); i.rd = 5'($urandom_range(0, 3));
      i.rsd = $urandom; i.rtd = $urandom;
      i.imm = (i.op == OP_RTYPE) ? {26'($urandom), fl[$urandom_range(0, 5)]} : $urandom;
      drive(i);
      set_wb(1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)), $urandom);
      bus.flush = ($urandom_range(0, 11) == 0);
      run1("rand");
    end
    bus.flush = 1'b0;
    for (int n = 0; n < 3; n++) begin
      set_wb(1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)), $urandom);
      drive(r_ins(F_MUL, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(1, 3)),
                  $urandom, $urandom));
      run_mul("rmul", 1'b1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/ex_stage.md
Name: ex_stage

Overview:
- Execute stage that consumes the ID/EX pipeline bundle, applies operand forwarding and performs the ALU operation.
- It owns the EX/MEM pipeline register and drives it directly.
- It contains an iterative 32-cycle multiplier. While the multiplier is busy, the stage stalls ID/EX and sends bubbles into EX/MEM.
- It sits between the ID/EX register and the data-memory stage.

Parameters:
- MUL_CYCLES, 32, number of iteration cycles for MUL; must equal the data width.
- DW, 32, datapath width.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  ID/EX holds a real instruction (0 = bubble)
- flush  in  1  synchronous kill of the in-flight instruction
- RegWrite_in, Mem2Reg_in, MemRead_in, MemWrite_in  in  1 each  WB/MEM controls from ID/EX
- ALUOp_in  in  2  00 add, 01 sub, 10 R-type (decode by funct), 11 or
- RegDst_in  in  1  1 selects rd as destination, 0 selects rt
- ALU_Src_in  in  1  1 selects immediate as operand B
- RsAddr_in, RtAddr_in, RdAddr_in  in  5 each  register addresses
- RsData_in, RtData_in, immediate_in  in  DW each  operands; funct = immediate_in[5:0]
- wb_RegWrite  in  1  MEM/WB write enable (forwarding source)
- wb_WriteAddr  in  5  MEM/WB destination register
- wb_data  in  DW  MEM/WB writeback value
- stall_o  out  1  ID/EX must hold its contents this cycle
- ex_valid  out  1  EX/MEM entry is a real instruction
- RegWrite_out, Mem2Reg_out, MemRead_out, MemWrite_out  out  1 each  registered controls to MEM
- alu_result  out  DW  registered result or memory address
- store_data  out  DW  registered forwarded Rt value
- WriteAddr_out  out  5  registered destination register

Behaviour:
- Reset: while rst_n=0, every registered output is 0 and FSM=IDLE. stall_o is 0 while in reset.
- R-type funct decode:
  - 0x20 add, 0x22 sub, 0x24 and, 0x25 or
  - 0x2A slt: signed compare, result 1 or 0
  - 0x18 mul: low DW bits of the unsigned product
  - any other funct: result 0, controls pass through unchanged.
- Arithmetic wraps modulo 2^DW; no overflow trap.
- Forwarding for operand A (from Rs) and raw B (from Rt), highest priority first:
  1. Own EX/MEM output, when ex_valid & RegWrite_out & !Mem2Reg_out & WriteAddr_out==addr & addr!=0.
  2. MEM/WB, when wb_RegWrite & wb_WriteAddr==addr & addr!=0.
  3. Otherwise the ID/EX data.
- Load-use hazards are excluded by the hazard unit elsewhere.
- ALU_Src selects immediate_in for operand B. store_data always takes the forwarded Rt value.
- Non-MUL instructions:
  - Single-cycle: EX/MEM outputs load on the next rising edge.
  - ex_valid follows in_valid.
  - When in_valid=0, all control outputs load 0.
- FSM states IDLE, BUSY, DONE:
  - IDLE: on in_valid & mul & !flush, capture the forwarded operands and all controls, clear the iteration count, go to BUSY. The EX/MEM register loads a bubble.
  - BUSY: one shift-add step per cycle. After MUL_CYCLES steps, go to DONE. EX/MEM loads a bubble.
  - DONE: EX/MEM loads the product with the captured controls, ex_valid=1, go to IDLE.
- stall_o = in_valid & mul & (state != DONE), combinational.
  - A MUL holds stall_o high for MUL_CYCLES+1 cycles (IDLE capture cycle plus BUSY cycles).
  - The result appears at the output MUL_CYCLES+2 edges after the first edge at which it was presented.
- Flush (priority over everything except reset):
  - FSM returns to IDLE, the iteration count clears, and EX/MEM loads a bubble on that edge.
  - stall_o=0 in the flush cycle.
- Operands captured for MUL are immune to later changes on the MEM/WB or ID/EX inputs.
- Back-to-back MULs: the second MUL is accepted in the IDLE cycle immediately after DONE.
- Reset asserted mid-MUL aborts it; no result is produced.

Decomposition:
- Shared package ex_pkg holds:
  - ALUOp encodings
  - funct constants (ADD, SUB, AND, OR, SLT, MUL)
  - FSM state enum (IDLE, BUSY, DONE)
  - DW default
- Sub-module mul_iter32 (shift-add, start/done handshake, count register) instantiated inside ex_stage; everything else stays in ex_stage.

Test Plan:
- Reset mid-run: pulse rst_n=0 -> all outputs 0, stall_o=0. After release, one add 3+4 gives alu_result=7 one edge later.
- Forwarding:
  - add r1=5+6, then add r2=r1+r1 with stale RsData_in=0 -> alu_result=22 (EX/MEM forward).
  - With only the MEM/WB match (wb_WriteAddr=1, wb_data=9) -> 18.
  - A destination of r0 is never forwarded.
- MUL latency: mul 0xFFFF_FFFF*3 with no flush -> stall_o high exactly 33 cycles, ex_valid=0 during them, then alu_result=0xFFFF_FFFD, ex_valid=1.
- Flush mid-MUL: assert flush at BUSY cycle 10 -> no result emitted, stall_o drops that cycle. The next add 1+1 yields 2 one edge later.
- slt signed: -1 slt 1 -> 1; 1 slt -1 -> 0. Unknown funct 0x3F -> alu_result=0 with controls passed through.
- Bubble and store: in_valid=0 -> all controls 0. sw with ALU_Src=1, imm=8, Rs=0x100, Rt forwarded 0xAB -> alu_result=0x108, store_data=0xAB, MemWrite_out=1.
